// File: rtl/scalar_mult_ctrl.sv
// scalar_mult_ctrl: left-to-right double-and-add sequencer for R = k*P.
// Holds the scalar shifter, the base point P and the running point R, and drives
// an external point_add unit through a start/done handshake. No field arithmetic here.
module scalar_mult_ctrl #(
    parameter int KW = 256,
    parameter int CW = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k,
    input  logic [CW-1:0] px,
    input  logic [CW-1:0] py,
    input  logic          pinf,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] rx,
    output logic [CW-1:0] ry,
    output logic          rinf,
    output logic          pa_start,
    output logic [CW-1:0] pa_x1,
    output logic [CW-1:0] pa_y1,
    output logic          pa_inf1,
    output logic [CW-1:0] pa_x2,
    output logic [CW-1:0] pa_y2,
    output logic          pa_inf2,
    input  logic          pa_done,
    input  logic [CW-1:0] pa_x3,
    input  logic [CW-1:0] pa_y3,
    input  logic          pa_inf3
);

    localparam int CNTW = (KW > 1) ? $clog2(KW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIT,
        S_DBL_REQ,
        S_DBL_WAIT,
        S_ADD_REQ,
        S_ADD_WAIT,
        S_NEXT,
        S_FIN
    } state_t;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          inf;
    } point_t;

    localparam point_t PT_INF = '{x: {CW{1'b0}}, y: {CW{1'b0}}, inf: 1'b1};

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    point_t          p_q, p_d;        // base point P
    point_t          r_q, r_d;        // running accumulator R
    point_t          res_q, res_d;    // published result
    point_t          op1_q, op1_d;    // point_add operand 1
    point_t          op2_q, op2_d;    // point_add operand 2
    logic            done_q, done_d;
    logic            pa_start_q, pa_start_d;
    point_t          pa_res;

    assign pa_res = '{x: pa_x3, y: pa_y3, inf: pa_inf3};

    // Next-state, datapath updates and handshake pulses.
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        p_d        = p_q;
        r_d        = r_q;
        res_d      = res_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        done_d     = 1'b0;
        pa_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d     = k;
                    p_d     = '{x: px, y: py, inf: pinf};
                    r_d     = PT_INF;
                    cnt_d   = CNTW'(KW - 1);
                    state_d = S_BIT;
                end
            end

            S_BIT: begin
                if (!r_q.inf) begin
                    op1_d      = r_q;
                    op2_d      = r_q;
                    pa_start_d = 1'b1;
                    state_d    = S_DBL_REQ;
                end else if (k_q[KW-1]) begin
                    op1_d      = r_q;
                    op2_d      = p_q;
                    pa_start_d = 1'b1;
                    state_d    = S_ADD_REQ;
                end else begin
                    // Leading zero bits with R at infinity do no work, so the
                    // shift/count step is folded in here: one cycle per such bit.
                    k_d = k_q << 1;
                    if (cnt_q == '0) begin
                        state_d = S_FIN;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
            end

            S_DBL_REQ: begin
                // pa_done is not looked at in the pa_start cycle: it may still
                // belong to the previous operation.
                state_d = S_DBL_WAIT;
            end

            S_DBL_WAIT: begin
                if (pa_done) begin
                    r_d = pa_res;
                    if (k_q[KW-1]) begin
                        op1_d      = pa_res;
                        op2_d      = p_q;
                        pa_start_d = 1'b1;
                        state_d    = S_ADD_REQ;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end

            S_ADD_REQ: begin
                state_d = S_ADD_WAIT;
            end

            S_ADD_WAIT: begin
                if (pa_done) begin
                    r_d     = pa_res;
                    state_d = S_NEXT;
                end
            end

            S_NEXT: begin
                k_d = k_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q - CNTW'(1);
                    state_d = S_BIT;
                end
            end

            S_FIN: begin
                res_d   = r_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; every register, including the wide point
    // registers, is cleared by reset so outputs are defined immediately.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            cnt_q      <= '0;
            p_q        <= PT_INF;
            r_q        <= PT_INF;
            res_q      <= PT_INF;
            op1_q      <= PT_INF;
            op2_q      <= PT_INF;
            done_q     <= 1'b0;
            pa_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            r_q        <= r_d;
            res_q      <= res_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            done_q     <= done_d;
            pa_start_q <= pa_start_d;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign rx       = res_q.x;
    assign ry       = res_q.y;
    assign rinf     = res_q.inf;
    assign pa_start = pa_start_q;
    assign pa_x1    = op1_q.x;
    assign pa_y1    = op1_q.y;
    assign pa_inf1  = op1_q.inf;
    assign pa_x2    = op2_q.x;
    assign pa_y2    = op2_q.y;
    assign pa_inf2  = op2_q.inf;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Testbench for scalar_mult_ctrl. The point_add partner is an abstract group
// model: a point with x = m*X0 (mod 2^256), y = x ^ YM behaves like m*P, so
// k*P has x = k*X0 and the expected results below are plain integer products.
module tb_scalar_mult_ctrl;

    localparam int KW     = 256;
    localparam int CW     = 256;
    localparam int PA_LAT = 3;
    localparam int BOUND  = 20000;

    localparam logic [CW-1:0] P0X = {8{32'h0123_4567}};
    localparam logic [CW-1:0] YM  = {8{32'h5A5A_0F0F}};
    localparam logic [CW-1:0] P0Y = P0X ^ YM;

    // Hand-computed multiples of P0X.
    localparam logic [CW-1:0] X2   = {8{32'h0246_8ACE}};
    localparam logic [CW-1:0] X3   = {8{32'h0369_D035}};
    localparam logic [CW-1:0] X165 = {8{32'hBBBB_BB63}};
    localparam logic [CW-1:0] XTOP = {1'b1, {(CW-1){1'b0}}};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k = '0;
    logic [CW-1:0] px = '0;
    logic [CW-1:0] py = '0;
    logic          pinf = 1'b0;
    logic          busy, done, rinf, pa_start;
    logic [CW-1:0] rx, ry;
    logic [CW-1:0] pa_x1, pa_y1, pa_x2, pa_y2;
    logic          pa_inf1, pa_inf2;
    logic          pa_done;
    logic [CW-1:0] pa_x3, pa_y3;
    logic          pa_inf3;

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    scalar_mult_ctrl #(.KW(KW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k(k), .px(px), .py(py), .pinf(pinf),
        .busy(busy), .done(done), .rx(rx), .ry(ry), .rinf(rinf),
        .pa_start(pa_start), .pa_x1(pa_x1), .pa_y1(pa_y1), .pa_inf1(pa_inf1),
        .pa_x2(pa_x2), .pa_y2(pa_y2), .pa_inf2(pa_inf2),
        .pa_done(pa_done), .pa_x3(pa_x3), .pa_y3(pa_y3), .pa_inf3(pa_inf3)
    );

    // pa_start pulses, counted on the edge that samples them
    always @(posedge clk) begin
        if (pa_start === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    // Group-law addition in the abstract model: returns {inf, x, y}.
    function automatic logic [2*CW:0] grp_add(input logic [CW-1:0] x1, input logic inf1,
                                              input logic [CW-1:0] y1,
                                              input logic [CW-1:0] x2, input logic inf2,
                                              input logic [CW-1:0] y2);
        logic [CW-1:0] s;
        if (inf1) return {inf2, x2, y2};
        if (inf2) return {1'b0, x1, y1};
        s = x1 + x2;
        if (s == '0) return {1'b1, {CW{1'b0}}, {CW{1'b0}}};
        return {1'b0, s, s ^ YM};
    endfunction

    // point_add model: fixed latency, 1-cycle done pulse, and a count of any
    // operand change while an operation is in flight.
    logic [CW-1:0] m_x1, m_y1, m_x2, m_y2;
    logic          m_inf1, m_inf2, m_busy;
    int            m_cnt, hold_err, b2b_err;
    logic          pa_start_prev;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_cnt <= 0; pa_done <= 1'b0;
            pa_x3 <= '0; pa_y3 <= '0; pa_inf3 <= 1'b1;
            m_x1 <= '0; m_y1 <= '0; m_x2 <= '0; m_y2 <= '0; m_inf1 <= 1'b1; m_inf2 <= 1'b1;
            hold_err <= 0; b2b_err <= 0; pa_start_prev <= 1'b0;
        end else begin
            pa_done <= 1'b0;
            pa_start_prev <= pa_start;
            if (pa_start && pa_start_prev) b2b_err <= b2b_err + 1;
            if (pa_start) begin
                m_x1 <= pa_x1; m_y1 <= pa_y1; m_inf1 <= pa_inf1;
                m_x2 <= pa_x2; m_y2 <= pa_y2; m_inf2 <= pa_inf2;
                m_busy <= 1'b1; m_cnt <= PA_LAT;
            end else if (m_busy) begin
                if ({pa_x1, pa_y1, pa_inf1, pa_x2, pa_y2, pa_inf2} !==
                    {m_x1, m_y1, m_inf1, m_x2, m_y2, m_inf2})
                    hold_err <= hold_err + 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    pa_done <= 1'b1;
                    {pa_inf3, pa_x3, pa_y3} <= grp_add(m_x1, m_inf1, m_y1, m_x2, m_inf2, m_y2);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One scalar multiplication. cyc counts clock edges from the edge that
    // samples start up to the edge after which done is seen. With glitch set,
    // a second start (k=3, pinf=1) is pulsed while the first op is running.
    task automatic run(input string tag, input logic [KW-1:0] kk, input logic pi,
                       input bit glitch, output int cyc, output int npulse);
        int base;
        base = pulse_cnt;
        @(negedge clk);
        k = kk; pinf = pi; px = P0X; py = P0Y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        check({tag, "_busy"}, {255'd0, busy}, 256'd1);
        while (done !== 1'b1 && cyc < BOUND) begin
            if (glitch && (cyc == 5 || cyc == 200)) begin
                start = 1'b1; k = 3; pinf = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, {255'd0, done}, 256'd1);
        check({tag, "_busy_at_done"}, {255'd0, busy}, 256'd0);
        npulse = pulse_cnt - base;
        @(negedge clk);
        check({tag, "_done_pulse"}, {255'd0, done}, 256'd0);
    endtask

    initial begin
        int cyc, np, w, base;

        // Reset state
        #12;
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_pa_start", {255'd0, pa_start}, 256'd0);
        check("rst_rx", rx, '0);
        check("rst_rinf", {255'd0, rinf}, 256'd1);
        check("rst_pa_inf1", {255'd0, pa_inf1}, 256'd1);
        check("rst_pa_inf2", {255'd0, pa_inf2}, 256'd1);
        check("rst_pa_x2", pa_x2, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // k=1: R = P, one add
        run("k1", 256'd1, 1'b0, 1'b0, cyc, np);
        check("k1_rx", rx, P0X);
        check("k1_ry", ry, P0Y);
        check("k1_rinf", {255'd0, rinf}, 256'd0);
        check("k1_pulses", np, 256'd1);

        // k=2: add then double
        run("k2", 256'd2, 1'b0, 1'b0, cyc, np);
        check("k2_rx", rx, X2);
        check("k2_ry", ry, X2 ^ YM);
        check("k2_pulses", np, 256'd2);

        // k=3: add, double, add
        run("k3", 256'd3, 1'b0, 1'b0, cyc, np);
        check("k3_rx", rx, X3);
        check("k3_ry", ry, X3 ^ YM);
        check("k3_pulses", np, 256'd3);

        // k=0: no operations, fixed latency
        run("k0", 256'd0, 1'b0, 1'b0, cyc, np);
        check("k0_rinf", {255'd0, rinf}, 256'd1);
        check("k0_pulses", np, 256'd0);
        check("k0_latency", cyc, KW + 2);

        // pinf=1: adds still issue, doubling never starts, result at infinity
        run("pinf", 256'd5, 1'b1, 1'b0, cyc, np);
        check("pinf_rinf", {255'd0, rinf}, 256'd1);
        check("pinf_pulses", np, 256'd2);

        // k=0xA5: 7 doubles + 4 adds
        run("kA5", 256'hA5, 1'b0, 1'b0, cyc, np);
        check("kA5_rx", rx, X165);
        check("kA5_pulses", np, 256'd11);

        // MSB-only scalar: 1 add + 255 doubles
        run("kmsb", {1'b1, 255'd0}, 1'b0, 1'b0, cyc, np);
        check("kmsb_rx", rx, XTOP);
        check("kmsb_rinf", {255'd0, rinf}, 256'd0);
        check("kmsb_pulses", np, 256'd256);

        // start while busy is ignored
        run("glitch", 256'd2, 1'b0, 1'b1, cyc, np);
        check("glitch_rx", rx, X2);
        check("glitch_pulses", np, 256'd2);
        repeat (3) @(negedge clk);
        check("hold_rx", rx, X2);
        check("hold_idle", {255'd0, busy}, 256'd0);

        // reset during DBL_WAIT of a k=3 run
        base = pulse_cnt;
        @(negedge clk);
        k = 256'd3; pinf = 1'b0; px = P0X; py = P0Y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (pulse_cnt - base < 2 && w < BOUND) begin
            @(negedge clk);
            w++;
        end
        check("mid_dbl_issued", pulse_cnt - base, 256'd2);
        check("mid_busy_before", {255'd0, busy}, 256'd1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", {255'd0, busy}, 256'd0);
        check("mid_done", {255'd0, done}, 256'd0);
        check("mid_pa_start", {255'd0, pa_start}, 256'd0);
        check("mid_rx", rx, '0);
        check("mid_ry", ry, '0);
        check("mid_rinf", {255'd0, rinf}, 256'd1);
        check("mid_pa_x1", pa_x1, '0);
        check("mid_pa_inf1", {255'd0, pa_inf1}, 256'd1);
        check("mid_pa_inf2", {255'd0, pa_inf2}, 256'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (PA_LAT + 2) @(negedge clk);
        check("mid_quiet", {255'd0, busy}, 256'd0);

        run("post_rst_k1", 256'd1, 1'b0, 1'b0, cyc, np);
        check("post_rx", rx, P0X);
        check("post_rinf", {255'd0, rinf}, 256'd0);
        check("post_pulses", np, 256'd1);

        // handshake properties over the runs since the last reset
        check("operand_hold", hold_err, 256'd0);
        check("no_back_to_back", b2b_err, 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
